// File: rtl/uart_echo_ctrl.sv
// Echo sequencer for the UART FIFO handshake: pops one RX byte, waits for TX space, pushes it.
// Optional macro ECHO_CRLF_EN appends 0x0A after every echoed 0x0D.
module uart_echo_ctrl #(
   parameter int unsigned TX_TIMEOUT = 1024,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             enable_i,
   input  logic             rx_empty_i,
   input  logic             tx_full_i,
   input  logic [7:0]       r_data_i,
   output logic             rd_uart_o,
   output logic             wr_uart_o,
   output logic [7:0]       w_data_o,
   output logic             busy_o,
   output logic             drop_o,
   output logic [CNT_W-1:0] echo_count_o,
   output logic [CNT_W-1:0] drop_count_o
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CAPTURE = 3'd1;
   localparam logic [2:0] S_WAIT_TX = 3'd2;
   localparam logic [2:0] S_SEND    = 3'd3;
`ifdef ECHO_CRLF_EN
   localparam logic [2:0] S_WAIT_LF = 3'd4;
   localparam logic [2:0] S_SEND_LF = 3'd5;
`endif
   localparam logic [15:0] TMO_LAST = 16'(TX_TIMEOUT - 1);

   logic [2:0]       state_q, state_d;
   logic [7:0]       hold_q, hold_d;
   logic [15:0]      tmo_q, tmo_d;
   logic             drop_q, drop_d;
   logic [CNT_W-1:0] echo_q, echo_d;
   logic [CNT_W-1:0] dcnt_q, dcnt_d;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      tmo_d   = tmo_q;
      drop_d  = 1'b0;
      echo_d  = echo_q;
      dcnt_d  = dcnt_q;
      case (state_q)
         S_IDLE: begin
            if (enable_i && !rx_empty_i) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            hold_d  = r_data_i;
            tmo_d   = '0;
            state_d = S_WAIT_TX;
         end
`ifdef ECHO_CRLF_EN
         S_WAIT_TX, S_WAIT_LF: begin
`else
         S_WAIT_TX: begin
`endif
            // A free TX slot on the last count cycle still sends: SEND beats drop.
            if (!tx_full_i) begin
`ifdef ECHO_CRLF_EN
               state_d = (state_q == S_WAIT_LF) ? S_SEND_LF : S_SEND;
`else
               state_d = S_SEND;
`endif
            end else if (tmo_q == TMO_LAST) begin
               drop_d  = 1'b1;
               dcnt_d  = dcnt_q + CNT_W'(1);
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_SEND: begin
            echo_d  = echo_q + CNT_W'(1);
            state_d = S_IDLE;
`ifdef ECHO_CRLF_EN
            if (hold_q == 8'h0D) begin
               state_d = S_WAIT_LF;
               tmo_d   = '0;
            end
`endif
         end
`ifdef ECHO_CRLF_EN
         S_SEND_LF: state_d = S_IDLE;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         hold_q  <= '0;
         tmo_q   <= '0;
         drop_q  <= 1'b0;
         echo_q  <= '0;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         tmo_q   <= tmo_d;
         drop_q  <= drop_d;
         echo_q  <= echo_d;
         dcnt_q  <= dcnt_d;
      end
   end

   // Strobes decode registered state only; no input reaches rd/wr combinationally.
   assign rd_uart_o = (state_q == S_CAPTURE);
`ifdef ECHO_CRLF_EN
   assign wr_uart_o = (state_q == S_SEND) || (state_q == S_SEND_LF);
   assign w_data_o  = (state_q == S_SEND_LF) ? 8'h0A : hold_q;
`else
   assign wr_uart_o = (state_q == S_SEND);
   assign w_data_o  = hold_q;
`endif
   assign busy_o       = (state_q != S_IDLE);
   assign drop_o       = drop_q;
   assign echo_count_o = echo_q;
   assign drop_count_o = dcnt_q;

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Scoreboard bench for uart_echo_ctrl: FIFO-like RX/TX stimulus with planned TX stall lengths.
module tb_uart_echo_ctrl;
   localparam int T  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset, enable, rx_empty, tx_full;
   logic [7:0]    r_data;
   logic          rd_uart, wr_uart, busy, drop;
   logic [7:0]    w_data;
   logic [CW-1:0] echo_count, drop_count;

   always #5 clk = ~clk;

   uart_echo_ctrl #(.TX_TIMEOUT(T), .CNT_W(CW)) dut (
      .clk_i(clk), .reset_i(reset), .enable_i(enable), .rx_empty_i(rx_empty),
      .tx_full_i(tx_full), .r_data_i(r_data), .rd_uart_o(rd_uart), .wr_uart_o(wr_uart),
      .w_data_o(w_data), .busy_o(busy), .drop_o(drop), .echo_count_o(echo_count),
      .drop_count_o(drop_count)
   );

   typedef struct {logic [7:0] b; bit dropped; int lat;} exp_t;
   exp_t       sbq[$];
   logic [7:0] rxq[$];
   int         plan_q[$];
   int         tests = 0, fails = 0;
   int         exp_echo = 0, exp_drop = 0;
   int         cyc = 0, rd_cyc = -100;
   bit         stalling = 0, pop_pending = 0, prev_rd = 0;
   int         j = 0, cur_l = 0;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
      end
   endtask

   // Driver: RX FIFO model plus TX-full stall window (cur_l full samples per byte).
   initial begin
      exp_t e;
      rx_empty = 1'b1; r_data = 8'h00; tx_full = 1'b0;
      forever begin
         @(negedge clk);
         if (pop_pending) begin
            if (rxq.size() > 0) void'(rxq.pop_front());
            pop_pending = 0;
         end
         if (stalling) begin
            if (wr_uart || drop) begin
               stalling = 0; tx_full = 1'b0;
            end else begin
               tx_full = (j < cur_l); j++;
            end
         end
         if (rd_uart && rxq.size() > 0) begin
            pop_pending = 1;
            cur_l = (plan_q.size() > 0) ? plan_q.pop_front() : 0;
            stalling = 1; j = 0; tx_full = 1'b0;
            e.b = rxq[0]; e.dropped = (cur_l >= T); e.lat = cur_l;
            sbq.push_back(e);
            if (e.dropped) exp_drop++; else exp_echo++;
`ifdef ECHO_CRLF_EN
            if (!e.dropped && e.b == 8'h0D) begin
               e.b = 8'h0A; e.dropped = 0; e.lat = -1;
               sbq.push_back(e);
            end
`endif
         end
         rx_empty = (rxq.size() == 0);
         r_data   = rx_empty ? 8'h00 : rxq[0];
      end
   end

   // Monitor: pops the scoreboard on every push or drop the DUT presents.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rd_uart) begin
            chk("rd_single", prev_rd, 0);
            chk("rd_nonempty", rxq.size() > 0, 1);
            rd_cyc = cyc;
         end
         prev_rd = rd_uart;
         if (wr_uart) begin
            chk("sb_nonempty_on_wr", sbq.size() > 0, 1);
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               chk("w_data", w_data, e.b);
               chk("wr_not_dropped", e.dropped, 0);
               if (e.lat >= 0) chk("wr_latency", cyc - rd_cyc, e.lat + 2);
            end
         end
         if (drop) begin
            chk("sb_nonempty_on_drop", sbq.size() > 0, 1);
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               chk("drop_expected", e.dropped, 1);
               chk("drop_latency", cyc - rd_cyc, T + 1);
            end
         end
      end
   end

   task automatic drain(input int budget);
      int k = 0;
      enable = 1'b1;
      while (!(rxq.size() == 0 && sbq.size() == 0 && !busy && !pop_pending) && k < budget) begin
         @(negedge clk); k++;
      end
      chk("drain_done", (rxq.size() == 0 && sbq.size() == 0 && !busy), 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      logic [7:0] b;
      int r, l, k;
      reset = 1'b1; enable = 1'b1;
      rxq.push_back(8'h41); plan_q.push_back(0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_rd", rd_uart, 0);
         chk("rst_wr", wr_uart, 0);
         chk("rst_busy", busy, 0);
      end
      chk("rst_w_data", w_data, 8'h00);
      chk("rst_drop", drop, 0);
      chk("rst_echo_cnt", echo_count, 0);
      chk("rst_drop_cnt", drop_count, 0);
      #2 reset = 1'b0;
      @(negedge clk);
      chk("first_rd_latency", rd_uart, 1);
      repeat (3) @(negedge clk);
      chk("single_echo_cnt", echo_count, 1);

      // Boundary stalls: release on final count, exact timeout, long stall.
      @(negedge clk); #2;
      rxq.push_back(8'hA5); plan_q.push_back(T - 1);
      rxq.push_back(8'h3C); plan_q.push_back(T);
      rxq.push_back(8'h0D); plan_q.push_back(10);
      rxq.push_back(8'h5A); plan_q.push_back(0);
      drain(500);
      chk("dir_echo_cnt", echo_count, exp_echo % (1 << CW));
      chk("dir_drop_cnt", drop_count, exp_drop % (1 << CW));

      @(negedge clk); #2;
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 6)) begin
            @(negedge clk); #2;
            enable = ($urandom_range(0, 3) != 0);
         end
         b = ($urandom_range(0, 9) == 0) ? 8'h0D : 8'($urandom);
         r = $urandom_range(0, 5);
         l = (r == 0) ? 0 : (r == 1) ? T - 1 : (r == 2) ? T : (r == 3) ? T + 5
             : $urandom_range(1, T - 2);
         rxq.push_back(b); plan_q.push_back(l);
      end
      drain(5000);
      chk("rand_echo_cnt", echo_count, exp_echo % (1 << CW));
      chk("rand_drop_cnt", drop_count, exp_drop % (1 << CW));

      // Reset while a popped byte is stalled in WAIT_TX.
      @(negedge clk); #2;
      rxq.push_back(8'h77); plan_q.push_back(T + 20);
      k = 0;
      while (!rd_uart && k < 100) begin @(negedge clk); k++; end
      chk("midrst_rd_seen", rd_uart, 1);
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b1;
      sbq.delete(); exp_echo = 0; exp_drop = 0;
      stalling = 0; tx_full = 1'b0;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_echo_cnt", echo_count, 0);
      chk("midrst_drop_cnt", drop_count, 0);
      #2 reset = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("midrst_no_wr", wr_uart, 0);
      end
      #2;
      rxq.push_back(8'h12); plan_q.push_back(0);
      rxq.push_back(8'h34); plan_q.push_back(2);
      drain(500);
      chk("post_echo_cnt", echo_count, exp_echo % (1 << CW));
      chk("post_drop_cnt", drop_count, exp_drop % (1 << CW));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_echo_ctrl.md
# uart_echo_ctrl

Sequencer that drives the UART's FIFO handshake (`rd_uart`/`wr_uart`) to echo every received byte back out on the transmit side. It sits beside the `uart` instance in the echo system. It polls `rx_empty`, pops one byte, waits for transmit FIFO space, and pushes the byte. A transmit-stall timeout keeps a blocked TX FIFO from hanging the receive path, and counters report echoed and dropped bytes.

## Interface
Parameters:
- `TX_TIMEOUT`, default 1024: cycles spent in WAIT_TX with `tx_full`=1 before the held byte is dropped; legal range 1..65535.
- `CNT_W`, default 16: width of `echo_count` and `drop_count`.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous reset, active-high.
- `enable` input 1: 1 allows a new byte to be started from IDLE.
- `rx_empty` input 1: UART RX FIFO empty flag.
- `tx_full` input 1: UART TX FIFO full flag.
- `r_data` input 8: UART RX FIFO head byte; valid while `rx_empty`=0.
- `rd_uart` output 1: one-cycle pop strobe to the RX FIFO.
- `wr_uart` output 1: one-cycle push strobe to the TX FIFO.
- `w_data` output 8: byte pushed to the TX FIFO; only meaningful while `wr_uart`=1.
- `busy` output 1: 1 in any state other than IDLE.
- `drop` output 1: one-cycle pulse when a byte is discarded on timeout.
- `echo_count` output `CNT_W`: number of received bytes successfully pushed.
- `drop_count` output `CNT_W`: number of bytes discarded on timeout.

## Operation
States: IDLE, CAPTURE, WAIT_TX, SEND, plus WAIT_LF and SEND_LF when built with `ECHO_CRLF_EN`.
- **IDLE**
  - If `enable`=1 and `rx_empty`=0, go to CAPTURE.
  - Otherwise stay in IDLE.
- **CAPTURE**
  - `hold` <= `r_data`.
  - `rd_uart`=1 for this cycle.
  - Always go to WAIT_TX.
  - Clear the timeout counter.
- **WAIT_TX**
  - If `tx_full`=0, go to SEND.
  - Otherwise increment the timeout counter.
  - When the counter reaches `TX_TIMEOUT`-1 with `tx_full` still 1: pulse `drop`, increment `drop_count`, go to IDLE.
- **SEND**
  - `wr_uart`=1 and `w_data`=`hold`.
  - Increment `echo_count`.
  - Go to WAIT_LF if CR handling applies (see Configuration); otherwise go to IDLE.
- **Outputs:** all strobes are Moore outputs decoded from registered state. No combinational path from inputs to `rd_uart` or `wr_uart`.
- **Counters:** both wrap modulo 2^`CNT_W` silently. Max value + 1 = 0.
- **`enable` deasserted mid-sequence:** the byte in flight completes normally. `enable` is sampled only in IDLE.
- **`reset`=1 in any state:**
  - Next state is IDLE; `hold`, the timeout counter, `echo_count` and `drop_count` clear to 0.
  - A byte already popped but not pushed is lost and not counted as dropped.
- **Reset values:** `rd_uart`=0, `wr_uart`=0, `w_data`=0x00, `busy`=0, `drop`=0, `echo_count`=0, `drop_count`=0.

## Timing
- **Minimum latency:** `rx_empty` observed 0 in IDLE at edge n. Then `rd_uart`=1 in cycle n+1, WAIT_TX in n+2, and `wr_uart`=1 in cycle n+3 if `tx_full`=0 at edge n+2.
- **Throughput:** at most one echoed byte every 4 cycles. SEND returns to IDLE, so back-to-back bytes are never pipelined.
- **Single pop:** `rd_uart` is exactly one cycle per byte. Never assert it twice without an intervening SEND or drop.
- **Timeout:** a byte is dropped exactly `TX_TIMEOUT` cycles after entering WAIT_TX if `tx_full` never falls. `tx_full` falling on the final count cycle goes to SEND; SEND wins over drop.
- **Empty/full:**
  - `rx_empty`=1 in IDLE: no pop.
  - `tx_full`=1: no push. `wr_uart` is never asserted while the sampled `tx_full` is 1.

## Configuration
- **`ECHO_CRLF_EN` defined:** after SEND of `hold`=0x0D, the FSM goes to WAIT_LF and then SEND_LF instead of IDLE.
  - WAIT_LF has the same wait and timeout rules as WAIT_TX. A timeout increments `drop_count`.
  - SEND_LF pushes 0x0A and does not increment `echo_count`.
  - A CR therefore takes at least 2 extra cycles.
- **`ECHO_CRLF_EN` undefined:** WAIT_LF and SEND_LF are absent. 0x0D is echoed like any other byte.

## Test plan
- **Reset:** reset held 3 cycles with `rx_empty`=0 -> all outputs at reset values, no `rd_uart` or `wr_uart` pulses.
- **Single byte:** `r_data`=0x41, `rx_empty` falls at edge n, `tx_full`=0 -> `rd_uart` pulse at n+1, `wr_uart` at n+3 with `w_data`=0x41, `echo_count`=1.
- **TX stall then release:** `tx_full`=1 for 10 cycles, then 0, `TX_TIMEOUT`=1024 -> exactly one `wr_uart`, `drop_count`=0.
- **Timeout:** `TX_TIMEOUT`=8, `tx_full` stuck at 1 -> `drop` pulses 8 cycles after entering WAIT_TX, `drop_count`=1, FSM back in IDLE, next byte is accepted.
- **Reset mid-operation:** reset asserted during WAIT_TX -> IDLE on the next edge, no `wr_uart`, both counters 0.
- **CRLF, `ECHO_CRLF_EN` defined:** byte 0x0D -> pushes 0x0D then 0x0A, `echo_count`=1. Without the macro: only 0x0D is pushed.
